// File: rtl/dmem_store_buffer_if.sv
// Wait-stated data-memory bus between the store buffer (master) and memory (slave).
// One transfer per mem_req; mem_ack is a single-cycle completion pulse.
interface dmem_store_buffer_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store buffer between the single-cycle core data port and a wait-stated bus.
// Stores are queued and drained in order; loads stall until every queued store has drained.
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWrite,
    input  logic                MemByte,
    input  logic                MemRead,
    input  logic [31:0]         Addr,
    input  logic [31:0]         WriteData,
    output logic [31:0]         ReadData,
    output logic                Stall,
    dmem_store_buffer_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WR, RD, RD_DONE} state_t;

    state_t             state, state_n;
    logic [29:0]        fifo_addr [DEPTH];
    logic [3:0]         fifo_be   [DEPTH];
    logic [31:0]        fifo_data [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, push, pop;
    logic [3:0]         be_new;
    logic [31:0]        data_new;
    logic [31:0]        rd_q;

    assign full     = (count == CNT_W'(DEPTH));
    assign Stall    = (MemWrite & full) | (MemRead & (state != RD_DONE));
    assign push     = MemWrite & ~Stall;
    assign pop      = (state == WR) & bus.mem_ack;
    assign be_new   = MemByte ? (4'b0001 << Addr[1:0]) : 4'b1111;
    assign data_new = MemByte ? {4{WriteData[7:0]}} : WriteData;
    assign ReadData = rd_q;

    // Entry storage carries no reset; only pointers and count decide validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= Addr[31:2];
            fifo_be[wr_ptr]   <= be_new;
            fifo_data[wr_ptr] <= data_new;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rd_q  <= '0;
        end else begin
            state <= state_n;
            if ((state == RD) && bus.mem_ack)
                rd_q <= bus.mem_rdata;
        end
    end

    // Bus sequencing: queued stores always win over a waiting load.
    always_comb begin
        state_n       = state;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                if (count != '0)
                    state_n = WR;
                else if (MemRead)
                    state_n = RD;
            end
            WR: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_be    = fifo_be[rd_ptr];
                bus.mem_addr  = {fifo_addr[rd_ptr], 2'b00};
                bus.mem_wdata = fifo_data[rd_ptr];
                if (bus.mem_ack)
                    state_n = IDLE;
            end
            RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_be   = 4'b1111;
                bus.mem_addr = {Addr[31:2], 2'b00};
                if (bus.mem_ack)
                    state_n = RD_DONE;
            end
            RD_DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: a transaction-level store-queue model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_dmem_store_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemByte = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        Stall;

    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        ack_en = 1'b0;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic [31:0] rd_val = 32'h0;

    int checks = 0;
    int errors = 0;

    // Model state: pending stores, observed write data, read result, per-cycle handshake facts
    wr_t         q[$];
    logic [31:0] obs[$];
    logic [31:0] exp_rd = 32'h0;
    logic        rd_done = 1'b0;
    logic        wr_ack_prev = 1'b0;
    logic        req_pend = 1'b0;

    always #5 clk = ~clk;

    dmem_store_buffer_if bus();

    assign bus.mem_ack   = resp_ack | stray_ack;
    assign bus.mem_rdata = rd_val;

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemByte   (MemByte),
        .MemRead   (MemRead),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .bus       (bus)
    );

    // Memory responder: ack ack_delay cycles after a request appears, one-cycle pulse
    always @(posedge clk) begin
        #1;
        if (!ack_en || !bus.mem_req || resp_ack) begin
            resp_ack = 1'b0;
            wcnt     = 0;
        end else if (wcnt >= ack_delay) begin
            resp_ack = 1'b1;
        end else begin
            wcnt++;
        end
    end

    // Model update just before each rising edge, from the values the DUT is about to clock in
    always @(negedge clk) begin
        wr_t  e;
        logic push_m;
        #4;
        if (!reset) begin
            q.delete();
            exp_rd      = 32'h0;
            rd_done     = 1'b0;
            wr_ack_prev = 1'b0;
            req_pend    = 1'b0;
        end else begin
            push_m      = MemWrite && (q.size() < DEPTH);
            e.addr      = {Addr[31:2], 2'b00};
            e.be        = MemByte ? (4'b0001 << Addr[1:0]) : 4'b1111;
            e.data      = MemByte ? {4{WriteData[7:0]}} : WriteData;
            wr_ack_prev = bus.mem_req && bus.mem_we && bus.mem_ack;
            rd_done     = bus.mem_req && !bus.mem_we && bus.mem_ack;
            req_pend    = bus.mem_req && !bus.mem_ack;
            if (wr_ack_prev) begin
                obs.push_back(bus.mem_wdata);
                if (q.size() > 0)
                    void'(q.pop_front());
            end
            if (rd_done)
                exp_rd = bus.mem_rdata;
            if (push_m)
                q.push_back(e);
        end
    end

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic exp_stall;
        if (!reset) begin
            chk_eq("rst_req", {31'b0, bus.mem_req}, 32'h0);
            chk_eq("rst_addr", bus.mem_addr, 32'h0);
            chk_eq("rst_rdata", ReadData, 32'h0);
        end else begin
            exp_stall = (MemWrite && (q.size() == DEPTH)) || (MemRead && !rd_done);
            chk_eq("stall", {31'b0, Stall}, {31'b0, exp_stall});
            chk_eq("readdata", ReadData, exp_rd);
            if (req_pend)
                chk_eq("req_hold", {31'b0, bus.mem_req}, 32'h1);
            if (wr_ack_prev)
                chk_eq("bubble", {31'b0, bus.mem_req}, 32'h0);
            if (bus.mem_req && bus.mem_we) begin
                chk_eq("wr_has_entry", {31'b0, q.size() != 0}, 32'h1);
                if (q.size() != 0) begin
                    chk_eq("wr_addr", bus.mem_addr, q[0].addr);
                    chk_eq("wr_be", {28'b0, bus.mem_be}, {28'b0, q[0].be});
                    chk_eq("wr_data", bus.mem_wdata, q[0].data);
                end
            end
            if (bus.mem_req && !bus.mem_we) begin
                chk_eq("rd_after_stores", q.size(), 32'h0);
                chk_eq("rd_addr", bus.mem_addr, {Addr[31:2], 2'b00});
                chk_eq("rd_be", {28'b0, bus.mem_be}, 32'hF);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        MemWrite = 1'b0;
        MemByte  = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b, output int stalls);
        bit done = 1'b0;
        MemWrite  = 1'b1;
        MemByte   = b;
        Addr      = a;
        WriteData = d;
        stalls    = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            if (!Stall) done = 1'b1;
            else        stalls++;
            tick();
        end
        if (!done)
            chk_eq("store_timeout", {31'b0, Stall}, 32'h0);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.mem_req && n < 20) begin
            tick();
            n++;
        end
        chk_eq(name, {31'b0, bus.mem_req}, 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < 200) begin
            tick();
            n++;
            if (!bus.mem_req && q.size() == 0) quiet++;
            else                               quiet = 0;
        end
        chk_eq("drain_timeout", quiet, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int base;
        int n;
        int rd_seen;
        bit done;

        repeat (3) tick();
        chk_eq("reset_stall", {31'b0, Stall}, 32'h0);
        chk_eq("reset_rdata", ReadData, 32'h0);
        reset = 1'b1;
        tick();

        // STR with ack one cycle after request
        ack_en = 1'b1;
        ack_delay = 1;
        store(32'h104, 32'hDEADBEEF, 1'b0, st);
        idle_inputs();
        chk_eq("str_nostall", st, 32'd0);
        wait_req("str_req");
        chk_eq("str_addr", bus.mem_addr, 32'h104);
        chk_eq("str_be", {28'b0, bus.mem_be}, 32'hF);
        chk_eq("str_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk_eq("str_we", {31'b0, bus.mem_we}, 32'h1);
        drain();

        // STRB to byte lane 3
        store(32'h203, 32'h123456AB, 1'b1, st);
        idle_inputs();
        wait_req("strb_req");
        chk_eq("strb_addr", bus.mem_addr, 32'h200);
        chk_eq("strb_be", {28'b0, bus.mem_be}, 32'h8);
        chk_eq("strb_wdata", bus.mem_wdata, 32'hABABABAB);
        drain();

        // Five back-to-back stores against a silent bus
        ack_en = 1'b0;
        base = obs.size();
        for (int i = 0; i < 4; i++) begin
            store(32'h10 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 1'b0, st);
            chk_eq("fill_nostall", st, 32'd0);
        end
        MemWrite  = 1'b1;
        Addr      = 32'h20;
        WriteData = 32'h55555555;
        repeat (3) begin
            #1;
            chk_eq("full_stall", {31'b0, Stall}, 32'h1);
            tick();
        end
        ack_delay = 0;
        ack_en = 1'b1;
        // Still full during the ack cycle itself, so two more stalled cycles before acceptance
        store(32'h20, 32'h55555555, 1'b0, st);
        idle_inputs();
        chk_eq("fifth_stalls", st, 32'd2);
        drain();
        chk_eq("drain_count", obs.size() - base, 32'd5);
        for (int i = 0; i < 5; i++)
            chk_eq("drain_order", obs[base + i], 32'h11111111 * 32'(i + 1));

        // Load behind two queued stores
        ack_en = 1'b0;
        base = obs.size();
        store(32'h300, 32'hA0A0A0A0, 1'b0, st);
        store(32'h304, 32'hB0B0B0B0, 1'b0, st);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        Addr     = 32'h104;
        rd_val   = 32'hCAFEF00D;
        ack_delay = 1;
        ack_en = 1'b1;
        #1;
        chk_eq("ld_stall_start", {31'b0, Stall}, 32'h1);
        rd_seen = -1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick();
            if (bus.mem_req && !bus.mem_we && rd_seen < 0)
                rd_seen = obs.size() - base;
            if (!Stall) done = 1'b1;
        end
        chk_eq("ld_release", {31'b0, Stall}, 32'h0);
        chk_eq("ld_writes_first", rd_seen, 32'd2);
        chk_eq("ld_data", ReadData, 32'hCAFEF00D);
        idle_inputs();
        repeat (2) tick();

        // Load with empty queue and immediate ack: minimum latency
        MemRead = 1'b1;
        Addr    = 32'h108;
        rd_val  = 32'h5A5AA5A5;
        ack_delay = 0;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (Stall) begin
                n++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        chk_eq("ld_min_stall", n, 32'd2);
        chk_eq("ld_min_data", ReadData, 32'h5A5AA5A5);
        idle_inputs();
        repeat (2) tick();

        // Reset in the middle of a write with three entries queued
        ack_en = 1'b0;
        store(32'h500, 32'h0F0F0F0F, 1'b0, st);
        store(32'h504, 32'h1E1E1E1E, 1'b0, st);
        store(32'h508, 32'h2D2D2D2D, 1'b0, st);
        idle_inputs();
        wait_req("mid_req");
        reset = 1'b0;
        #1;
        chk_eq("mid_rst_req", {31'b0, bus.mem_req}, 32'h0);
        chk_eq("mid_rst_we", {31'b0, bus.mem_we}, 32'h0);
        chk_eq("mid_rst_be", {28'b0, bus.mem_be}, 32'h0);
        chk_eq("mid_rst_addr", bus.mem_addr, 32'h0);
        chk_eq("mid_rst_wdata", bus.mem_wdata, 32'h0);
        chk_eq("mid_rst_rdata", ReadData, 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        ack_delay = 1;
        ack_en = 1'b1;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        n = 0;
        repeat (6) begin
            tick();
            if (bus.mem_req) n++;
        end
        chk_eq("post_rst_quiet", n, 32'd0);
        base = obs.size();
        store(32'h600, 32'h77777777, 1'b0, st);
        idle_inputs();
        drain();
        chk_eq("post_rst_count", obs.size() - base, 32'd1);
        if (obs.size() > base)
            chk_eq("post_rst_data", obs[base], 32'h77777777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
